neuron_layer_sequencer: RTL

Drives one fully connected spiking layer for a single time step. It latches an input spike vector and, for every output neuron in turn, streams that neuron's weights from an external synchronous weight memory. Weights for inputs that spiked are accumulated into the neuron's membrane potential; a fire/reset decision follows. The block owns the membrane state for all neurons and sits between the input spike source and the next layer or readout logic.

---
 rtl/neuron_layer_sequencer_pkg.sv | 24 ++
 rtl/neuron_layer_sequencer_lif_update.sv | 29 ++
 rtl/neuron_layer_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/neuron_layer_sequencer_pkg.sv
// Shared types and widths for the spiking layer sequencer and its LIF arithmetic.
package neuron_layer_sequencer_pkg;

    localparam int MEM_W = 9;
    localparam int WGT_W = 8;
    localparam int TH_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_FIRE,
        S_DONE
    } state_e;

    typedef enum logic {
        LIF_ACC,
        LIF_FIRE
    } lif_mode_e;

    function automatic logic [MEM_W-1:0] sext_w(input logic [WGT_W-1:0] w);
        return {{(MEM_W-WGT_W){w[WGT_W-1]}}, w};
    endfunction

endpackage

// File: rtl/neuron_layer_sequencer_lif_update.sv
// Combinational membrane arithmetic: 9-bit wrapping accumulate, or threshold fire with reset-to-zero.
module lif_update
    import neuron_layer_sequencer_pkg::*;
(
    input  logic [MEM_W-1:0] v_mem_i,
    input  logic [WGT_W-1:0] weight_i,
    input  logic [TH_W-1:0]  v_th_i,
    input  lif_mode_e        mode_i,
    output logic [MEM_W-1:0] v_next_o,
    output logic             spike_o
);

    logic [MEM_W-1:0] diff;

    // Fire test is the sign of the wrapped difference, not a signed compare.
    assign diff = v_mem_i - {1'b0, v_th_i};

    always_comb begin
        v_next_o = v_mem_i;
        spike_o  = 1'b0;
        if (mode_i == LIF_ACC) begin
            v_next_o = v_mem_i + sext_w(weight_i);
        end else begin
            spike_o = ~diff[MEM_W-1];
            if (spike_o) v_next_o = '0;
        end
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// Sequences one time step of a fully connected spiking layer: streams weights per neuron,
// accumulates spiking inputs into per-neuron membranes, then fires and publishes the spike vector.
module neuron_layer_sequencer
    import neuron_layer_sequencer_pkg::*;
#(
    parameter int N_INPUTS  = 16,
    parameter int N_NEURONS = 10,
    parameter int ADDR_W    = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 start,
    input  logic                 clear_mem,
    input  logic [N_INPUTS-1:0]  in_spikes,
    input  logic [TH_W-1:0]      v_th,
    output logic                 weight_rd_en,
    output logic [ADDR_W-1:0]    weight_addr,
    input  logic [WGT_W-1:0]     weight_data,
    output logic                 busy,
    output logic                 done,
    output logic [N_NEURONS-1:0] out_spikes
);

    localparam int IW = $clog2(N_INPUTS + 1);
    localparam int NW = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IW-1:0] I_LAST  = IW'(N_INPUTS - 1);
    localparam logic [IW-1:0] I_DRAIN = IW'(N_INPUTS);
    localparam logic [NW-1:0] N_LAST  = NW'(N_NEURONS - 1);

    state_e                 state_q;
    logic [NW-1:0]          n_q;
    logic [IW-1:0]          i_q;
    logic [N_INPUTS-1:0]    spk_q;
    logic [TH_W-1:0]        vth_q;
    logic [N_NEURONS-1:0]   sh_q;
    logic [N_NEURONS-1:0]   sh_d;
    logic                   acc_en_q;
    logic [MEM_W-1:0]       v_mem_q [N_NEURONS];

    logic [N_INPUTS:0]      spk_ext;
    lif_mode_e              lif_mode;
    logic [MEM_W-1:0]       lif_v_next;
    logic                   lif_spike;

    // Extra zero bit lets the drain index (N_INPUTS) select safely.
    assign spk_ext  = {1'b0, spk_q};
    assign lif_mode = (state_q == S_FIRE) ? LIF_FIRE : LIF_ACC;

    lif_update u_lif (
        .v_mem_i  (v_mem_q[n_q]),
        .weight_i (weight_data),
        .v_th_i   (vth_q),
        .mode_i   (lif_mode),
        .v_next_o (lif_v_next),
        .spike_o  (lif_spike)
    );

    always_comb begin
        sh_d      = sh_q;
        sh_d[n_q] = lif_spike;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            n_q          <= '0;
            i_q          <= '0;
            spk_q        <= '0;
            vth_q        <= '0;
            sh_q         <= '0;
            acc_en_q     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            weight_rd_en <= 1'b0;
            weight_addr  <= '0;
            out_spikes   <= '0;
            for (int k = 0; k < N_NEURONS; k++) v_mem_q[k] <= '0;
        end else begin
            done     <= 1'b0;
            // Weight data returns one cycle after the read, so gate it with the delayed spike bit.
            acc_en_q <= weight_rd_en & spk_ext[i_q];
            case (state_q)
                S_IDLE: begin
                    if (clear_mem) begin
                        for (int k = 0; k < N_NEURONS; k++) v_mem_q[k] <= '0;
                    end else if (start) begin
                        spk_q        <= in_spikes;
                        vth_q        <= v_th;
                        n_q          <= '0;
                        i_q          <= '0;
                        busy         <= 1'b1;
                        weight_rd_en <= 1'b1;
                        weight_addr  <= '0;
                        state_q      <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (acc_en_q) v_mem_q[n_q] <= lif_v_next;
                    if (i_q == I_DRAIN) begin
                        state_q <= S_FIRE;
                    end else begin
                        i_q <= i_q + IW'(1);
                        if (i_q == I_LAST) weight_rd_en <= 1'b0;
                        else               weight_addr  <= weight_addr + ADDR_W'(1);
                    end
                end
                S_FIRE: begin
                    v_mem_q[n_q] <= lif_v_next;
                    sh_q         <= sh_d;
                    if (n_q == N_LAST) begin
                        out_spikes <= sh_d;
                        done       <= 1'b1;
                        state_q    <= S_DONE;
                    end else begin
                        n_q          <= n_q + NW'(1);
                        i_q          <= '0;
                        weight_rd_en <= 1'b1;
                        weight_addr  <= weight_addr + ADDR_W'(1);
                        state_q      <= S_ACCUM;
                    end
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
